priority_queue: RTL and testbench
=================================

Name: priority_queue

Overview:
- Distance store and minimum-finder for the Dijkstra engine.
- Holds one VALUE_WIDTH distance per node and supports single-port read/write through a shared bidirectional bus.
- Continuously reports the unvisited node with the smallest distance.
- Sits between the graph-walk controller, which supplies the prev vector and issues distance updates, and the node-selection logic, which consumes min_index/min_value.

Parameters:
- MAX_NODES, 8, number of nodes/distance entries.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH (8), width of a node index.
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH (16), width of a distance value.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- set_en  in  1  1 = write value into dist[index] at next rising edge; 0 = read.
- index  in  INDEX_WIDTH  node addressed for read/write.
- prev_vector_flattened  in  INDEX_WIDTH*MAX_NODES  entry j at bits [INDEX_WIDTH*j +: INDEX_WIDTH]; equal to `UNVISITED means node j is unvisited.
- value  inout  VALUE_WIDTH  driven by block with dist[index] when set_en=0; high-Z when set_en=1, when the controller drives write data.
- min_index  out  INDEX_WIDTH  index of smallest-distance unvisited node.
- min_value  out  VALUE_WIDTH  that node's distance.

Behaviour:
- Storage: dist[0..MAX_NODES-1], VALUE_WIDTH each.
- Reset (reset=0, asynchronous assert, synchronous-safe release): dist[0]=0 (source) and all other entries = `INFINITY. Reset dominates set_en.
- Write: at a rising edge with reset=1 and set_en=1, dist[index] <= value. The result is visible on value/min outputs right after that edge.
- Out-of-range write (index >= MAX_NODES) is ignored.
- Read: combinational. While set_en=0, value = dist[index]. Out-of-range index reads `INFINITY.
- The block never drives value while set_en=1, so there is no bus contention.
- Min search is purely combinational from dist[] and prev_vector_flattened, with zero cycle latency:
  - Candidates are nodes j with prev entry == `UNVISITED.
  - min_value = smallest candidate dist.
  - min_index = its index.
  - Ties resolve to the lowest index.
  - If no candidate exists, or all candidates are `INFINITY, min_value=`INFINITY and min_index = lowest-index candidate, or 0 if none.
- Values after reset: min_value=0, min_index=0, because node 0 holds 0 and is unvisited.
- Arithmetic is unsigned compare only; no overflow possible. `INFINITY compares as the maximum value.
- Writing `INFINITY to the source is legal and removes it as the minimum.

Decomposition:
- Shared constants file (constants.v / package) holds:
  - `DEFAULT_INDEX_WIDTH=8
  - `DEFAULT_VALUE_WIDTH=16
  - `INFINITY={VALUE_WIDTH{1'b1}} (16'hFFFF at default)
  - `UNVISITED={INDEX_WIDTH{1'b1}}
- One sub-module, pq_min_reduce: a parameterized combinational compare tree over (valid, value, index) tuples, lower index winning ties.
- Register file, bus tri-state and reset logic stay in priority_queue.

Test Plan:
- Reset: drive reset=0 for 2 cycles, then release with all prev=`UNVISITED and set_en=0 -> index 0 reads 0, indices 1..7 read 16'hFFFF; min_value=0, min_index=0.
- Source overwrite: set_en=1, index=0, value=16'hFFFF for one edge -> min_value=16'hFFFF; min_index=0 (tie rule).
- Random fill: for index 0..7 write urandom%50 then read back -> value equals written data; min_value equals running minimum; min_index points at its first occurrence.
- Visited masking: write dist={0,5,3,9,...}, set prev[2]=0 (visited) -> min_value=0 at index 0; also set prev[0]=1 -> min_value=5, min_index=1.
- Ties/all visited: dist[3]=dist[6]=4 as the only minimum -> min_index=3; mark every prev != `UNVISITED -> min_value=16'hFFFF, min_index=0.
- Async reset mid-operation: assert reset between edges while set_en=1 -> dist returns to reset values immediately; the write is discarded; min outputs read 0/0 without a clock.

Source files
------------

// File: rtl/priority_queue_pkg.sv
// Shared widths and sentinel helpers for the Dijkstra distance store.
package priority_queue_pkg;

  localparam int DEFAULT_INDEX_WIDTH = 8;
  localparam int DEFAULT_VALUE_WIDTH = 16;
  localparam int DEFAULT_MAX_NODES   = 8;

  // Sentinels are all-ones at whatever width the instance uses.
  function automatic logic [63:0] all_ones(input int width);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 64; b++) begin
      if (b < width) r[b] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pq_min_reduce.sv
// Combinational minimum over (valid, value) entries; the entry position is its index.
module pq_min_reduce #(
  parameter int N           = 8,
  parameter int INDEX_WIDTH = 8,
  parameter int VALUE_WIDTH = 16
) (
  input  logic [N-1:0]             valid_i,
  input  logic [N*VALUE_WIDTH-1:0] value_i,
  output logic [INDEX_WIDTH-1:0]   min_index_o,
  output logic [VALUE_WIDTH-1:0]   min_value_o
);

  logic found;

  // Strict less-than keeps the earliest candidate on ties, and when every
  // candidate holds the maximum value the first candidate is still reported.
  always_comb begin
    found       = 1'b0;
    min_index_o = '0;
    min_value_o = '1;
    for (int j = 0; j < N; j++) begin
      if (valid_i[j] && (!found || value_i[VALUE_WIDTH*j +: VALUE_WIDTH] < min_value_o)) begin
        found       = 1'b1;
        min_index_o = INDEX_WIDTH'(j);
        min_value_o = value_i[VALUE_WIDTH*j +: VALUE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/priority_queue.sv
// Distance register file with a shared read/write bus and a live unvisited-minimum output.
module priority_queue
  import priority_queue_pkg::*;
#(
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           set_en,
  input  logic [INDEX_WIDTH-1:0]         index,
  input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
  inout  wire  [VALUE_WIDTH-1:0]         value,
  output logic [INDEX_WIDTH-1:0]         min_index,
  output logic [VALUE_WIDTH-1:0]         min_value
);

  localparam logic [VALUE_WIDTH-1:0] INFINITY  = VALUE_WIDTH'(all_ones(VALUE_WIDTH));
  localparam logic [INDEX_WIDTH-1:0] UNVISITED = INDEX_WIDTH'(all_ones(INDEX_WIDTH));

  logic [VALUE_WIDTH-1:0]           dist_q [MAX_NODES];
  logic [VALUE_WIDTH-1:0]           dist_d [MAX_NODES];
  logic [VALUE_WIDTH-1:0]           rd_data;
  logic [MAX_NODES-1:0]             cand;
  logic [MAX_NODES*VALUE_WIDTH-1:0] dist_flat;

  // Index decode by comparison so out-of-range addresses simply match nothing.
  always_comb begin
    rd_data = INFINITY;
    for (int j = 0; j < MAX_NODES; j++) begin
      dist_d[j] = dist_q[j];
      if (index == INDEX_WIDTH'(j)) begin
        rd_data = dist_q[j];
        if (set_en) dist_d[j] = value;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < MAX_NODES; j++) begin
        dist_q[j] <= (j == 0) ? '0 : INFINITY;
      end
    end else begin
      for (int j = 0; j < MAX_NODES; j++) begin
        dist_q[j] <= dist_d[j];
      end
    end
  end

  assign value = set_en ? {VALUE_WIDTH{1'bz}} : rd_data;

  always_comb begin
    for (int j = 0; j < MAX_NODES; j++) begin
      cand[j] = (prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH] == UNVISITED);
      dist_flat[VALUE_WIDTH*j +: VALUE_WIDTH] = dist_q[j];
    end
  end

  pq_min_reduce #(
    .N           (MAX_NODES),
    .INDEX_WIDTH (INDEX_WIDTH),
    .VALUE_WIDTH (VALUE_WIDTH)
  ) u_min (
    .valid_i     (cand),
    .value_i     (dist_flat),
    .min_index_o (min_index),
    .min_value_o (min_value)
  );

endmodule

// File: tb/tb_priority_queue.sv
// Directed bench for priority_queue with a reference distance/visited model and expected queue.
module tb_priority_queue;

  localparam int N  = 8;
  localparam int IW = 8;
  localparam int VW = 16;
  localparam logic [VW-1:0] INF = 16'hFFFF;
  localparam logic [IW-1:0] UNV = 8'hFF;

  logic          clock;
  logic          reset;
  logic          set_en;
  logic [IW-1:0] index;
  logic [IW*N-1:0] prev_flat;
  wire  [VW-1:0] value;
  logic [VW-1:0] drv;
  logic [IW-1:0] min_index;
  logic [VW-1:0] min_value;

  logic [VW-1:0] model_dist [N];
  logic [IW-1:0] model_prev [N];
  logic [31:0]   exp_q [$];
  int            pass_cnt;
  int            total_cnt;

  assign value = set_en ? drv : {VW{1'bz}};

  priority_queue #(.MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .set_en                (set_en),
    .index                 (index),
    .prev_vector_flattened (prev_flat),
    .value                 (value),
    .min_index             (min_index),
    .min_value             (min_value)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // watchdog keeps the run bounded
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int j = 0; j < N; j++) model_dist[j] = (j == 0) ? '0 : INF;
  endtask

  task automatic apply_prev();
    for (int j = 0; j < N; j++) prev_flat[IW*j +: IW] = model_prev[j];
    #1;
  endtask

  task automatic compare(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %0h with no expected value queued", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic write(input logic [IW-1:0] i, input logic [VW-1:0] d);
    @(negedge clock);
    set_en = 1'b1;
    index  = i;
    drv    = d;
    @(posedge clock);
    #1;
    set_en = 1'b0;
    if (i < N) model_dist[i] = d;
    #1;
  endtask

  task automatic read_check(input logic [IW-1:0] i);
    index = i;
    exp_q.push_back(32'((i < N) ? model_dist[i[2:0]] : INF));
    #1;
    compare($sformatf("read[%0d]", i), 32'(value));
  endtask

  task automatic min_check(input string tag);
    logic          found;
    logic [VW-1:0] bv;
    logic [IW-1:0] bi;
    found = 1'b0; bv = INF; bi = '0;
    for (int j = 0; j < N; j++) begin
      if (model_prev[j] == UNV) begin
        if (!found) begin found = 1'b1; bv = model_dist[j]; bi = IW'(j); end
        else if (model_dist[j] < bv) begin bv = model_dist[j]; bi = IW'(j); end
      end
    end
    exp_q.push_back(32'(bv));
    exp_q.push_back(32'(bi));
    #1;
    compare({tag, ".min_value"}, 32'(min_value));
    compare({tag, ".min_index"}, 32'(min_index));
  endtask

  initial begin
    logic [VW-1:0] fill [N];
    logic [VW-1:0] mask_vals [N];
    logic [VW-1:0] tie_vals [N];
    pass_cnt  = 0;
    total_cnt = 0;
    mask_vals = '{16'd0, 16'd5, 16'd3, 16'd9, 16'd20, 16'd30, 16'd40, 16'd50};
    tie_vals  = '{16'd10, 16'd10, 16'd10, 16'd4, 16'd10, 16'd10, 16'd4, 16'd10};

    reset  = 1'b0;
    set_en = 1'b0;
    index  = '0;
    drv    = '0;
    for (int j = 0; j < N; j++) model_prev[j] = UNV;
    apply_prev();
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;

    // reset contents and minimum
    for (int j = 0; j < N; j++) read_check(IW'(j));
    min_check("reset");

    // source overwritten with infinity: all candidates infinite, lowest wins
    write(8'd0, INF);
    read_check(8'd0);
    min_check("src_inf");

    // random fill with running minimum
    for (int j = 0; j < N; j++) fill[j] = VW'($urandom_range(0, 49));
    for (int j = 0; j < N; j++) begin
      write(IW'(j), fill[j]);
      read_check(IW'(j));
      min_check($sformatf("fill%0d", j));
    end

    // visited masking
    for (int j = 0; j < N; j++) write(IW'(j), mask_vals[j]);
    model_prev[2] = 8'd0;
    apply_prev();
    min_check("mask_p2");
    model_prev[0] = 8'd1;
    apply_prev();
    min_check("mask_p0");

    // ties resolve to lowest index
    for (int j = 0; j < N; j++) model_prev[j] = UNV;
    apply_prev();
    for (int j = 0; j < N; j++) write(IW'(j), tie_vals[j]);
    min_check("tie");

    // everything visited
    for (int j = 0; j < N; j++) model_prev[j] = 8'd0;
    apply_prev();
    min_check("all_visited");

    // all candidates infinite with node 0 visited
    for (int j = 0; j < N; j++) write(IW'(j), INF);
    for (int j = 1; j < N; j++) model_prev[j] = UNV;
    apply_prev();
    min_check("all_inf");

    // out-of-range write ignored, out-of-range read returns infinity
    write(8'd8, 16'd1);
    write(8'd200, 16'd2);
    read_check(8'd8);
    read_check(8'd9);
    min_check("oor");

    // asynchronous reset between edges while a write is pending
    for (int j = 0; j < N; j++) model_prev[j] = UNV;
    apply_prev();
    write(8'd3, 16'd7);
    read_check(8'd3);
    @(negedge clock);
    set_en = 1'b1;
    index  = 8'd3;
    drv    = 16'd1;
    #2;
    reset = 1'b0;
    model_reset();
    min_check("async_rst");
    @(posedge clock);
    #1;
    set_en = 1'b0;
    read_check(8'd3);
    read_check(8'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    read_check(8'd3);
    min_check("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
